// File: rtl/uart_tx.sv
// UART transmitter that pops words from a first-word-fall-through FIFO and
// shifts the low DATA_BITS out as start / LSB-first data / stop frames.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int DVSR       = 326,
    parameter int FIFO_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST      = BAUD_W'(DVSR - 1);
    localparam logic [4:0]        BIT_TICK_LAST  = 5'd15;
    localparam logic [4:0]        STOP_TICK_LAST = 5'(SB_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST       = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_next;
    logic [BAUD_W-1:0]    baud_cnt, baud_next;
    logic [4:0]           tick_cnt, tick_next;
    logic [IDX_W-1:0]     bit_idx, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_reg, tx_next;
    logic                 done_reg, done_next;
    logic                 tick;
    logic                 pop;
    logic                 unused_fifo_bits;

    // Only the low DATA_BITS are transmitted; the rest of the word is dropped.
    assign unused_fifo_bits = ^fifo_rd_data;

    assign tick    = (baud_cnt == BAUD_LAST);
    assign pop     = (state == IDLE) && tx_en && !fifo_empty && !rst;
    assign fifo_rd = pop;
    assign tx      = tx_reg;
    assign busy    = (state != IDLE);
    assign tx_done = done_reg;

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        tick_next  = tick_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        done_next  = 1'b0;
        tx_next    = 1'b1;

        if (state != IDLE) begin
            baud_next = tick ? '0 : baud_cnt + BAUD_W'(1);
        end

        unique case (state)
            IDLE: begin
                baud_next = '0;
                if (pop) begin
                    shift_next = fifo_rd_data[DATA_BITS-1:0];
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt == BIT_TICK_LAST) begin
                        tick_next  = '0;
                        state_next = DATA;
                    end else begin
                        tick_next = tick_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt == BIT_TICK_LAST) begin
                        tick_next = '0;
                        if (bit_idx == IDX_LAST) begin
                            state_next = STOP;
                        end else begin
                            shift_next = shift_reg >> 1;
                            bit_next   = bit_idx + IDX_W'(1);
                        end
                    end else begin
                        tick_next = tick_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt == STOP_TICK_LAST) begin
                        tick_next  = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tick_next = tick_cnt + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The line level is chosen from the upcoming state so tx leaves a flop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            tick_cnt <= tick_next;
            bit_idx  <= bit_next;
            tx_reg   <= tx_next;
            done_reg <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        shift_reg <= shift_next;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DVSR = 4: one instance with 1 stop bit and
// one with 2 stop bits, fed by a small first-word-fall-through FIFO model.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rd_data = 32'h0;
    logic        fifo_rd, tx, busy, tx_done;

    logic        fifo_empty2 = 1'b1;
    logic [31:0] fifo_rd_data2 = 32'h0;
    logic        fifo_rd2, tx2, busy2, tx_done2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] q[$];
    int          pops = 0;
    int          pop_cyc[$];

    logic log_tx   [0:1299];
    logic log_busy [0:1299];
    logic log_done [0:1299];
    logic log_rd   [0:1299];
    logic log_tx2  [0:1299];
    logic log_busy2[0:1299];
    logic log_done2[0:1299];

    uart_tx #(.DATA_BITS(8), .SB_TICKS(16), .DVSR(4), .FIFO_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd), .tx(tx),
        .busy(busy), .tx_done(tx_done)
    );

    uart_tx #(.DATA_BITS(8), .SB_TICKS(32), .DVSR(4), .FIFO_WIDTH(32)) dut_sb2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty2),
        .fifo_rd_data(fifo_rd_data2), .fifo_rd(fifo_rd2), .tx(tx2),
        .busy(busy2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FWFT FIFO: a pop seen at an edge exposes the next head word 1 ns later.
    always @(posedge clk) begin : fifo_model
        logic rd;
        int   c;
        rd = fifo_rd;
        c  = cyc;
        #1;
        if (rd && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
            pop_cyc.push_back(c);
        end
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() == 0) ? 32'hDEAD0000 : q[0];
    end

    // Expected line level at offset o after the pop, for a 64-cycle bit time.
    function automatic logic exp_tx(input logic [7:0] d, input int o);
        if (o < 64) return 1'b0;
        else if (o < 576) return d[(o - 64) / 64];
        else return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample(input int o);
        log_tx[o]    = tx;
        log_busy[o]  = busy;
        log_done[o]  = tx_done;
        log_rd[o]    = fifo_rd;
        log_tx2[o]   = tx2;
        log_busy2[o] = busy2;
        log_done2[o] = tx_done2;
    endtask

    task automatic run_log(input int from, input int to, input int drop_at);
        for (int o = from; o < to; o++) begin
            step();
            sample(o);
            if (o == drop_at) tx_en = 1'b0;
        end
    endtask

    task automatic wait_pop(output int p, output bit ok);
        ok = 1'b0;
        p  = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (fifo_rd === 1'b1) begin
                p  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst   = 1'b1;
        tx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || tx_done !== 1'b0 ||
                tx2 !== 1'b1 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: tx=%b busy=%b fifo_rd=%b tx_done=%b, expected 1 0 0 0",
                         i, tx, busy, fifo_rd, tx_done);
            end
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || tx_done !== 1'b0 ||
                tx2 !== 1'b1 || busy2 !== 1'b0 || fifo_rd2 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_single_frame();
        int p, base, cnt, dcnt;
        bit ok;
        base = pops;
        q.push_back(32'h000000A5);
        wait_pop(p, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_pop: no fifo_rd within 50 cycles, expected one");
            return;
        end
        run_log(0, 642, -1);
        for (int b = 0; b < 10; b++) begin
            cnt = 0;
            for (int o = b * 64; o < b * 64 + 64; o++)
                if (log_tx[o] !== exp_tx(8'hA5, o)) cnt++;
            checks++;
            if (cnt != 0) begin
                errors++;
                $display("FAIL single_bit%0d: %0d cycles wrong, expected tx=%b for 64 cycles",
                         b, cnt, exp_tx(8'hA5, b * 64));
            end
        end
        checks++;
        if (log_busy[0] !== 1'b1 || log_busy[639] !== 1'b1 || log_busy[640] !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: busy first/last/after=%b%b%b, expected 110",
                     log_busy[0], log_busy[639], log_busy[640]);
        end
        dcnt = 0;
        for (int o = 0; o < 642; o++) if (log_done[o] === 1'b1) dcnt++;
        checks++;
        if (log_done[640] !== 1'b1 || dcnt != 1) begin
            errors++;
            $display("FAIL single_done: tx_done at 640=%b pulses=%0d, expected 1 and 1",
                     log_done[640], dcnt);
        end
        checks++;
        if (pops - base != 1) begin
            errors++;
            $display("FAIL single_pops: %0d pops, expected 1", pops - base);
        end
    endtask

    task automatic test_back_to_back();
        int p, base, pc, e1, e2;
        bit ok;
        base = pops;
        pc   = pop_cyc.size();
        q.push_back(32'h12345655);
        q.push_back(32'hABCDEFFF);
        wait_pop(p, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_pop: no fifo_rd within 50 cycles, expected one");
            return;
        end
        run_log(0, 1284, -1);
        checks++;
        if (pops - base != 2) begin
            errors++;
            $display("FAIL b2b_pops: %0d pops, expected 2", pops - base);
        end else begin
            checks++;
            if (pop_cyc[pc + 1] - pop_cyc[pc] != 641) begin
                errors++;
                $display("FAIL b2b_spacing: pops %0d cycles apart, expected 641",
                         pop_cyc[pc + 1] - pop_cyc[pc]);
            end
        end
        checks++;
        if (log_tx[640] !== 1'b1 || log_busy[640] !== 1'b0 || log_rd[640] !== 1'b1 ||
            log_done[640] !== 1'b1 || log_tx[641] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: tx=%b busy=%b rd=%b done=%b next_tx=%b, expected 1 0 1 1 0",
                     log_tx[640], log_busy[640], log_rd[640], log_done[640], log_tx[641]);
        end
        e1 = 0;
        e2 = 0;
        for (int o = 0; o < 640; o++) begin
            if (log_tx[o] !== exp_tx(8'h55, o)) e1++;
            if (log_tx[o + 641] !== exp_tx(8'hFF, o)) e2++;
        end
        checks++;
        if (e1 != 0) begin
            errors++;
            $display("FAIL b2b_frame1: %0d cycles wrong, expected 0x55 frame", e1);
        end
        checks++;
        if (e2 != 0 || log_done[1281] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frame2: %0d cycles wrong done=%b, expected 0 and done=1", e2, log_done[1281]);
        end
    endtask

    task automatic test_stop_bits();
        int e, hi;
        step();
        fifo_rd_data2 = 32'hFFFFFFC3;
        fifo_empty2   = 1'b0;
        #1;
        checks++;
        if (fifo_rd2 !== 1'b1) begin
            errors++;
            $display("FAIL sb2_pop: fifo_rd=%b, expected 1", fifo_rd2);
        end
        step();
        fifo_empty2 = 1'b1;
        sample(0);
        run_log(1, 706, -1);
        e = 0;
        for (int o = 0; o < 704; o++) if (log_tx2[o] !== exp_tx(8'hC3, o)) e++;
        checks++;
        if (e != 0) begin
            errors++;
            $display("FAIL sb2_frame: %0d cycles wrong, expected 0xC3 frame", e);
        end
        hi = 0;
        for (int o = 576; o < 704; o++) if (log_tx2[o] === 1'b1 && log_busy2[o] === 1'b1) hi++;
        checks++;
        if (hi != 128) begin
            errors++;
            $display("FAIL sb2_stop_len: stop lasted %0d cycles, expected 128", hi);
        end
        checks++;
        if (log_busy2[704] !== 1'b0 || log_done2[704] !== 1'b1 || log_done2[703] !== 1'b0) begin
            errors++;
            $display("FAIL sb2_frame_len: busy=%b done=%b at 704, done=%b at 703, expected 0 1 0",
                     log_busy2[704], log_done2[704], log_done2[703]);
        end
    endtask

    task automatic test_enable_gating();
        int p, base, e, rd, idle_bad;
        bit ok;
        base = pops;
        q.push_back(32'h0000003C);
        q.push_back(32'h00000096);
        wait_pop(p, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL en_pop: no fifo_rd within 50 cycles, expected one");
            return;
        end
        run_log(0, 700, 200);
        e = 0;
        for (int o = 0; o < 640; o++) if (log_tx[o] !== exp_tx(8'h3C, o)) e++;
        checks++;
        if (e != 0 || log_done[640] !== 1'b1) begin
            errors++;
            $display("FAIL en_frame1: %0d cycles wrong done=%b, expected 0 and done=1", e, log_done[640]);
        end
        rd = 0;
        idle_bad = 0;
        for (int o = 0; o < 700; o++) if (log_rd[o] === 1'b1) rd++;
        for (int o = 640; o < 700; o++) if (log_tx[o] !== 1'b1 || log_busy[o] !== 1'b0) idle_bad++;
        checks++;
        if (rd != 0 || idle_bad != 0) begin
            errors++;
            $display("FAIL en_gated: %0d pops %0d non-idle cycles while disabled, expected 0 0", rd, idle_bad);
        end
        tx_en = 1'b1;
        #1;
        checks++;
        if (fifo_rd !== 1'b1) begin
            errors++;
            $display("FAIL en_resume: fifo_rd=%b in enable cycle, expected 1", fifo_rd);
        end
        run_log(0, 642, -1);
        e = 0;
        for (int o = 0; o < 640; o++) if (log_tx[o] !== exp_tx(8'h96, o)) e++;
        checks++;
        if (e != 0 || pops - base != 2) begin
            errors++;
            $display("FAIL en_frame2: %0d cycles wrong pops=%0d, expected 0 and 2", e, pops - base);
        end
    endtask

    task automatic test_reset_midframe();
        int p, base, e;
        bit ok;
        base = pops;
        q.push_back(32'h0000000F);
        q.push_back(32'h000000E1);
        wait_pop(p, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_pop: no fifo_rd within 50 cycles, expected one");
            return;
        end
        run_log(0, 289, -1);
        checks++;
        if (log_tx[288] !== 1'b1 || log_busy[288] !== 1'b1) begin
            errors++;
            $display("FAIL rst_bit3: tx=%b busy=%b mid bit 3, expected 1 1", log_tx[288], log_busy[288]);
        end
        rst = 1'b1;
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: tx=%b busy=%b fifo_rd=%b tx_done=%b, expected 1 0 0 0",
                     tx, busy, fifo_rd, tx_done);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_rd !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh_pop: fifo_rd=%b after reset, expected 1", fifo_rd);
        end
        run_log(0, 642, -1);
        e = 0;
        for (int o = 0; o < 640; o++) if (log_tx[o] !== exp_tx(8'hE1, o)) e++;
        checks++;
        if (e != 0 || log_done[640] !== 1'b1) begin
            errors++;
            $display("FAIL rst_next_word: %0d cycles wrong done=%b, expected 0xE1 frame and done=1",
                     e, log_done[640]);
        end
        checks++;
        if (pops - base != 2) begin
            errors++;
            $display("FAIL rst_pops: %0d pops, expected 2", pops - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stop_bits();
        test_enable_gating();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains the first-word-fall-through FIFO and sends each word as an asynchronous UART frame. It sits directly downstream of the FIFO read interface: it watches the FIFO's empty flag, pops one word at a time, and shifts it out on a single `tx` line. It contains its own baud-tick generator with 16x oversampling.

## Interface
- `DATA_BITS`, 8, data bits per frame; the low `DATA_BITS` of the FIFO word are sent.
- `SB_TICKS`, 16, stop-bit length in oversample ticks; legal values are 16, 24 and 32 (1, 1.5 and 2 stop bits).
- `DVSR`, 326, clock cycles per oversample tick; must be ≥ 2. The default gives 9600 baud at 50 MHz.
- `FIFO_WIDTH`, 32, width of the FIFO read data; must be ≥ `DATA_BITS`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_en`  in  1  enable; while low, no new frame is started.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_data`  in  FIFO_WIDTH  FIFO head word; valid whenever `fifo_empty` = 0.
- `fifo_rd`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line; idle level is high.
- `busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - `tx` = 1.
  - If `tx_en` = 1 and `fifo_empty` = 0:
    - assert `fifo_rd` for exactly this cycle;
    - latch `fifo_rd_data[DATA_BITS-1:0]` into the shift register;
    - clear the baud counter, tick counter and bit index;
    - go to START.
- **START**
  - `tx` = 0 for 16 ticks, then go to DATA.
- **DATA**
  - `tx` = shift register bit 0, i.e. LSB first.
  - Every 16 ticks, shift right by one and increment the bit index.
  - After `DATA_BITS` bits, go to STOP.
- **STOP**
  - `tx` = 1 for `SB_TICKS` ticks, then go to IDLE.
  - Pulse `tx_done` for one cycle on the STOP→IDLE transition.
- **Baud generator**
  - Counter width is $clog2(DVSR).
  - It counts 0 to DVSR-1 and wraps.
  - The tick is asserted when the count is DVSR-1.
  - The counter is held at 0 in IDLE.
- **Counter widths**
  - Tick counter: 5 bits, wraps at 15 in START and DATA, and at `SB_TICKS-1` in STOP.
  - Bit index: $clog2(DATA_BITS) bits, minimum 1.
- `fifo_rd` is never asserted when `fifo_empty` = 1, and never outside IDLE.
- **`tx_en` deasserted mid-frame:** the current frame completes; the block then waits in IDLE.
- **`fifo_empty` rising mid-frame:** no effect on the current frame.
- **Upper FIFO bits** (`FIFO_WIDTH-1:DATA_BITS`) are ignored.
- `tx` is driven from a register, so the line is glitch-free.

## Timing
- **Reset values:** `tx` = 1, `fifo_rd` = 0, `busy` = 0, `tx_done` = 0, FSM in IDLE, all counters 0.
- **Reset mid-frame:**
  - On the edge that samples `rst` = 1, `tx` returns to 1 and the FSM goes to IDLE.
  - The word being sent is lost; it is not re-read.
  - No `fifo_rd` is issued while `rst` = 1.
- **Pop cycle (cycle 0):** `fifo_rd` is high in the same cycle that IDLE sees the pop condition.
- **Cycle 1 onward:**
  - `tx` = 0 and `busy` = 1 from the next edge (cycle 1).
  - `busy` stays high until the STOP→IDLE edge.
- **Phase durations:**
  - Start bit: 16·DVSR cycles.
  - Each data bit: 16·DVSR cycles.
  - Stop: `SB_TICKS`·DVSR cycles.
- **Frame length:**
  - From the first `tx` = 0 cycle to the return to IDLE: (16 + 16·DATA_BITS + SB_TICKS)·DVSR cycles.
  - `tx_done` is high during the first IDLE cycle.
- **Back-to-back frames:** the next `fifo_rd` occurs in that same first IDLE cycle, so there is exactly 1 idle `tx` = 1 cycle between the end of the stop bit and the next start bit.
- **FIFO handshake:** the FIFO must present its next head word by the cycle after `fifo_rd`, which a first-word-fall-through FIFO satisfies.

## Test plan
- **Reset and idle:** hold `rst` for 3 cycles with `fifo_empty` = 1.
  - Required: `tx` = 1, `busy` = 0, `fifo_rd` = 0 throughout, with no activity for 1000 cycles.
- **Single frame (DVSR = 4, defaults):** present 0x000000A5 with `fifo_empty` = 0 for one word.
  - Required: exactly one `fifo_rd` pulse.
  - Required: `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles.
  - Required: `tx_done` pulses 640 cycles after the start bit began.
- **Back-to-back frames:** FIFO holds 0x55 then 0xFF.
  - Required: two pops, 641 cycles apart.
  - Required: one idle-high cycle between frames; the second frame's data bits are all 1.
- **Stop-bit length (SB_TICKS = 32, DVSR = 4):**
  - Required: stop bit lasts 128 cycles.
  - Required: frame length is 16·4 + 128·4 + 32·4 = 704 cycles.
- **Enable gating:** drop `tx_en` during the data bits of frame 1 while the FIFO is non-empty.
  - Required: frame 1 completes intact, and no `fifo_rd` occurs until `tx_en` returns high.
  - Required: when `tx_en` returns high, `fifo_rd` is asserted in that same cycle.
- **Reset mid-frame:** assert `rst` for 1 cycle in the middle of data bit 3.
  - Required: `tx` = 1 and `busy` = 0 on the next edge.
  - Required: after reset, the next frame starts with a fresh pop and carries the next FIFO word.
